// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle MIPS control unit.
//   mc_state_e  - 5-bit FSM state encoding (also exported on state_o)
//   Alu*        - ALU operation codes driven on ALUOP
//   Op*/Fn*     - recognised opcode and funct values
//   decode_next - DECODE-state dispatch from {opcode, funct} to the first execute state
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    StIdle     = 5'd0,
    StFetch    = 5'd1,
    StDecode   = 5'd2,
    StMemAddr  = 5'd3,
    StMemRead  = 5'd4,
    StMemWb    = 5'd5,
    StMemWrite = 5'd6,
    StExecute  = 5'd7,
    StAluWb    = 5'd8,
    StBranch   = 5'd9,
    StImmExec  = 5'd10,
    StImmWb    = 5'd11,
    StJump     = 5'd12,
    StJr       = 5'd13,
    StJalWb    = 5'd14,
    StJalJump  = 5'd15,
    StTrap     = 5'd16
  } mc_state_e;

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluXor  = 3'd2;
  localparam logic [2:0] AluSlt  = 3'd3;
  localparam logic [2:0] AluAnd  = 3'd4;
  localparam logic [2:0] AluNand = 3'd5;
  localparam logic [2:0] AluNor  = 3'd6;
  localparam logic [2:0] AluOr   = 3'd7;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnXor = 6'h26;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  function automatic logic is_rtype_alu(logic [5:0] fn);
    case (fn)
      FnAdd, FnSub, FnAnd, FnOr, FnXor, FnNor, FnSlt: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic mc_state_e decode_next(logic [5:0] op, logic [5:0] fn);
    mc_state_e nxt;
    case (op)
      OpLw, OpSw:                          nxt = StMemAddr;
      OpRtype: begin
        if (is_rtype_alu(fn))              nxt = StExecute;
        else if (fn == FnJr)               nxt = StJr;
        else                               nxt = StTrap;
      end
      OpBeq, OpBne:                        nxt = StBranch;
      OpAddi, OpSlti, OpAndi, OpOri, OpXori: nxt = StImmExec;
      OpJ:                                 nxt = StJump;
      OpJal:                               nxt = StJalWb;
      default:                             nxt = StTrap;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decode.sv
// mc_alu_decode: combinational ALU operation select for the multicycle control unit.
//   state  in  current FSM state
//   opcode in  instruction opcode (selects immediate ALU ops)
//   funct  in  instruction funct (selects R-type ALU ops)
//   aluop  out ALU operation; ADD unless the state needs something else
module mc_alu_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 3
) (
  input  mc_state_e            state,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUOP_W-1:0]   aluop
);

  logic [5:0] op6;
  logic [5:0] fn6;
  logic [2:0] alu;

  assign op6 = 6'(opcode);
  assign fn6 = 6'(funct);

  always_comb begin
    alu = AluAdd;
    case (state)
      // ALU_WB keeps the EXECUTE operation so the result stays stable during writeback.
      StExecute, StAluWb: begin
        case (fn6)
          FnSub:   alu = AluSub;
          FnAnd:   alu = AluAnd;
          FnOr:    alu = AluOr;
          FnXor:   alu = AluXor;
          FnNor:   alu = AluNor;
          FnSlt:   alu = AluSlt;
          default: alu = AluAdd;
        endcase
      end
      StBranch: alu = AluSub;
      StImmExec: begin
        case (op6)
          OpSlti:  alu = AluSlt;
          OpAndi:  alu = AluAnd;
          OpOri:   alu = AluOr;
          OpXori:  alu = AluXor;
          default: alu = AluAdd;
        endcase
      end
      default: alu = AluAdd;
    endcase
  end

  assign aluop = ALUOP_W'(alu);

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit (fetch/decode/execute/memory/writeback).
//   clk, reset_n        clock; synchronous active-low reset to IDLE
//   opcode, funct       instruction fields from the instruction register
//   mem_ready           memory handshake, honoured only when FSM_MEM_WAIT_EN is defined
//   PCWE..BEQSel        single-bit datapath controls
//   ALUOP               ALU operation
//   RegDest, MemToReg, ALUSrcB, PCSrc  2-bit mux selects
//   instr_done          pulse in the last state of each instruction
//   illegal             high while trapped on an unknown instruction
//   state_o             current state for debug
// Build option FSM_MEM_WAIT_EN: FETCH, MEM_READ and MEM_WRITE stall until mem_ready, with their
// memory-side enables gated by it. Without it mem_ready is ignored.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               PCWE,
  output logic               IorD,
  output logic               MemWE,
  output logic               IRWrite,
  output logic               RegSr,
  output logic               RegWE,
  output logic               ALUSrcA,
  output logic               Branch,
  output logic               BEQSel,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic [1:0]         RegDest,
  output logic [1:0]         MemToReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               instr_done,
  output logic               illegal,
  output logic [4:0]         state_o
);

  mc_state_e  state_q, state_d;
  logic       mem_ok;
  logic [5:0] op6;
  logic [5:0] fn6;

  assign op6 = 6'(opcode);
  assign fn6 = 6'(funct);

`ifdef FSM_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:     state_d = StFetch;
      StFetch:    state_d = mem_ok ? StDecode : StFetch;
      StDecode:   state_d = decode_next(op6, fn6);
      StMemAddr:  state_d = (op6 == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  state_d = mem_ok ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ok ? StFetch : StMemWrite;
      StExecute:  state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StImmExec:  state_d = StImmWb;
      StImmWb:    state_d = StFetch;
      StJump:     state_d = StFetch;
      StJr:       state_d = StFetch;
      StJalWb:    state_d = StJalJump;
      StJalJump:  state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StIdle;  // unused encodings recover through IDLE
    endcase
  end

  mc_alu_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W)
  ) u_alu_decode (
    .state  (state_q),
    .opcode (opcode),
    .funct  (funct),
    .aluop  (ALUOP)
  );

  always_comb begin
    PCWE       = 1'b0;
    IorD       = 1'b0;
    MemWE      = 1'b0;
    IRWrite    = 1'b0;
    RegSr      = 1'b1;
    RegWE      = 1'b0;
    ALUSrcA    = 1'b0;
    Branch     = 1'b0;
    BEQSel     = 1'b0;
    RegDest    = 2'd0;
    MemToReg   = 2'd0;
    ALUSrcB    = 2'd0;
    PCSrc      = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        PCWE    = mem_ok;
        IRWrite = mem_ok;
        ALUSrcB = 2'd1;
      end
      StDecode: ALUSrcB = 2'd3;
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      StMemRead: IorD = 1'b1;
      StMemWb: begin
        MemToReg   = 2'd1;
        RegWE      = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        IorD       = 1'b1;
        MemWE      = mem_ok;
        instr_done = mem_ok;
      end
      StExecute: ALUSrcA = 1'b1;
      StAluWb: begin
        RegDest    = 2'd1;
        RegWE      = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        PCSrc      = 2'd1;
        Branch     = 1'b1;
        BEQSel     = (op6 == OpBne);
        instr_done = 1'b1;
      end
      StImmExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      StImmWb: begin
        RegWE      = 1'b1;
        instr_done = 1'b1;
      end
      StJump, StJalJump: begin
        PCWE       = 1'b1;
        PCSrc      = 2'd2;
        instr_done = 1'b1;
      end
      StJr: begin
        PCWE       = 1'b1;
        PCSrc      = 2'd3;
        RegSr      = 1'b0;
        instr_done = 1'b1;
      end
      StJalWb: begin
        RegDest  = 2'd2;
        MemToReg = 2'd2;
        RegWE    = 1'b1;
      end
      StTrap: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule
